// File: rtl/disp_arbiter_pkg.sv
// Shared constants and payload types for the display arbiter slice.
package disp_arbiter_pkg;

    localparam int unsigned STATE_W  = 2;
    localparam int unsigned DIGIT_W  = 8;
    localparam int unsigned FRAME_W  = 32;

    // Arbiter state encoding
    localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
    localparam logic [STATE_W-1:0] ST_OWN0 = 2'b01;
    localparam logic [STATE_W-1:0] ST_OWN1 = 2'b10;

    // Active-low segments: all ones turns every segment off
    localparam logic [DIGIT_W-1:0] BLANK_PAT = 8'hFF;

    // Four-digit frame, digit k in bits [8k+7:8k]
    typedef struct packed {
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } frame_t;

endpackage

// File: rtl/disp_arbiter_dwell.sv
// Saturating dwell counter; expired_c flags that MAX_COUNT cycles have elapsed.
module dwell_timer #(
    parameter int unsigned MAX_COUNT = 50_000_000,
    parameter int unsigned CNT_W     = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] count;

    // Clear wins over enable; counting stops at LAST
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = (count == LAST);

endmodule

// File: rtl/disp_arbiter.sv
// Two-source arbiter for the 4-digit display with round-robin and minimum dwell.
module disp_arbiter
    import disp_arbiter_pkg::*;
#(
    parameter int unsigned        DWELL_CYCLES = 50_000_000,
    parameter int unsigned        CNT_W        = 26,
    parameter logic [DIGIT_W-1:0] BLANK        = BLANK_PAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [FRAME_W-1:0] frame0,
    input  logic               req1,
    input  logic [FRAME_W-1:0] frame1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic [DIGIT_W-1:0] in0,
    output logic [DIGIT_W-1:0] in1,
    output logic [DIGIT_W-1:0] in2,
    output logic [DIGIT_W-1:0] in3
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic               last_owner;
    logic               dwell_clear;
    logic               dwell_en;
    logic               dwell_expired;
    frame_t             f0;
    frame_t             f1;
    frame_t             sel_frame;

    assign f0 = frame_t'(frame0);
    assign f1 = frame_t'(frame1);

    dwell_timer #(
        .MAX_COUNT (DWELL_CYCLES),
        .CNT_W     (CNT_W)
    ) u_dwell (
        .clk       (clk),
        .reset     (reset),
        .clear     (dwell_clear),
        .en        (dwell_en),
        .expired_c (dwell_expired)
    );

    // State and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
        end else begin
            state <= next_state;
            if ((next_state != state) && (next_state != ST_IDLE)) begin
                last_owner <= (next_state == ST_OWN1);
            end
        end
    end

    // Next-state: release beats dwell, dwell gates pre-emption
    always_comb begin
        next_state  = state;
        dwell_clear = 1'b0;
        dwell_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    next_state = last_owner ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    next_state = ST_OWN0;
                end else if (req1) begin
                    next_state = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    next_state = req1 ? ST_OWN1 : ST_IDLE;
                end else if (dwell_expired && req1) begin
                    next_state = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    next_state = req0 ? ST_OWN0 : ST_IDLE;
                end else if (dwell_expired && req0) begin
                    next_state = ST_OWN0;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        dwell_clear = (next_state != state);
        dwell_en    = (state != ST_IDLE);
    end

    // Frame seen by the display after the coming edge
    always_comb begin
        sel_frame = '{d3: BLANK, d2: BLANK, d1: BLANK, d0: BLANK};
        case (next_state)
            ST_OWN0: sel_frame = f0;
            ST_OWN1: sel_frame = f1;
            default: sel_frame = '{d3: BLANK, d2: BLANK, d1: BLANK, d0: BLANK};
        endcase
    end

    // Registered grants and segment patterns, aligned with the owning state
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
            in0  <= BLANK;
            in1  <= BLANK;
            in2  <= BLANK;
            in3  <= BLANK;
        end else begin
            gnt0 <= (next_state == ST_OWN0);
            gnt1 <= (next_state == ST_OWN1);
            busy <= (next_state != ST_IDLE);
            in0  <= sel_frame.d0;
            in1  <= sel_frame.d1;
            in2  <= sel_frame.d2;
            in3  <= sel_frame.d3;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: two instances (dwell 8 and dwell 4) share stimulus
// and are compared every checked cycle against an ownership-level model.
module tb_disp_arbiter;

    logic        clk;
    logic        reset;
    logic        req0;
    logic        req1;
    logic [31:0] frame0;
    logic [31:0] frame1;

    logic       a_gnt0, a_gnt1, a_busy;
    logic [7:0] a_in0, a_in1, a_in2, a_in3;
    logic       b_gnt0, b_gnt1, b_busy;
    logic [7:0] b_in0, b_in1, b_in2, b_in3;

    logic [34:0] obs [2];

    int tests_run;
    int tests_failed;
    int cyc;

    // Reference model: who owns each display, for how long, and who owned last
    int          m_own  [2];
    int          m_held [2];
    int          m_last [2];
    logic [31:0] m_out  [2];
    int          dwell  [2];

    disp_arbiter #(.DWELL_CYCLES(8), .CNT_W(4), .BLANK(8'hFF)) dut_a (
        .clk(clk), .reset(reset), .req0(req0), .frame0(frame0),
        .req1(req1), .frame1(frame1), .gnt0(a_gnt0), .gnt1(a_gnt1),
        .busy(a_busy), .in0(a_in0), .in1(a_in1), .in2(a_in2), .in3(a_in3)
    );

    disp_arbiter #(.DWELL_CYCLES(4), .CNT_W(4), .BLANK(8'hFF)) dut_b (
        .clk(clk), .reset(reset), .req0(req0), .frame0(frame0),
        .req1(req1), .frame1(frame1), .gnt0(b_gnt0), .gnt1(b_gnt1),
        .busy(b_busy), .in0(b_in0), .in1(b_in1), .in2(b_in2), .in3(b_in3)
    );

    assign obs[0] = {a_gnt0, a_gnt1, a_busy, a_in3, a_in2, a_in1, a_in0};
    assign obs[1] = {b_gnt0, b_gnt1, b_busy, b_in3, b_in2, b_in1, b_in0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [34:0] expv(input int k);
        return {m_own[k] == 0, m_own[k] == 1, m_own[k] != -1, m_out[k]};
    endfunction

    // One clock edge: advance the model with the inputs present at the edge
    task automatic step();
        int nxt;
        int mine;
        int other;
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_own[k]  = -1;
                m_held[k] = 0;
                m_last[k] = 1;
            end else begin
                nxt = m_own[k];
                if (m_own[k] == -1) begin
                    if (req0 && req1) nxt = (m_last[k] == 1) ? 0 : 1;
                    else if (req0)    nxt = 0;
                    else if (req1)    nxt = 1;
                end else begin
                    mine  = (m_own[k] == 0) ? int'(req0) : int'(req1);
                    other = (m_own[k] == 0) ? int'(req1) : int'(req0);
                    if (mine == 0)
                        nxt = (other != 0) ? 1 - m_own[k] : -1;
                    else if ((m_held[k] + 1 >= dwell[k]) && (other != 0))
                        nxt = 1 - m_own[k];
                end
                if (nxt != m_own[k]) begin
                    m_held[k] = 0;
                    if (nxt != -1) m_last[k] = nxt;
                end else if (nxt != -1) begin
                    m_held[k]++;
                end
                m_own[k] = nxt;
            end
            m_out[k] = (m_own[k] == 0) ? frame0 :
                       (m_own[k] == 1) ? frame1 : 32'hFFFF_FFFF;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
        frame0 = 32'h1122_3344; frame1 = 32'h5566_7788;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (obs[k] !== expv(k)) begin
                    tests_failed++;
                    $display("FAIL reset_hold dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], expv(k));
                end
            end
        end
        tests_run++;
        if ({a_gnt0, a_gnt1, a_busy, a_in0, a_in3} !== {3'b000, 8'hFF, 8'hFF}) begin
            tests_failed++;
            $display("FAIL reset_values: got %b %b %b %h %h expected 0 0 0 ff ff", a_gnt0, a_gnt1, a_busy, a_in0, a_in3);
        end
        reset = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs[k] !== expv(k)) begin
                tests_failed++;
                $display("FAIL reset_first_grant dut%0d: got %h expected %h", k, obs[k], expv(k));
            end
        end
        tests_run++;
        if ({a_gnt0, a_gnt1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL first_contention: got gnt0=%b gnt1=%b expected gnt0=1 gnt1=0", a_gnt0, a_gnt1);
        end
    endtask

    task automatic test_frame();
        req0 = 1'b1; req1 = 1'b0;
        frame0 = 32'hC0F9_A4B0;
        step();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs[k] !== expv(k)) begin
                tests_failed++;
                $display("FAIL frame_slices dut%0d: got %h expected %h", k, obs[k], expv(k));
            end
        end
        tests_run++;
        if ({a_gnt0, a_in0, a_in1, a_in2, a_in3} !== {1'b1, 8'hB0, 8'hA4, 8'hF9, 8'hC0}) begin
            tests_failed++;
            $display("FAIL frame_order: got gnt0=%b %h %h %h %h expected 1 b0 a4 f9 c0", a_gnt0, a_in0, a_in1, a_in2, a_in3);
        end
        frame0 = 32'h9999_9999;
        step();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs[k] !== expv(k)) begin
                tests_failed++;
                $display("FAIL frame_live dut%0d: got %h expected %h", k, obs[k], expv(k));
            end
        end
    endtask

    task automatic test_preempt();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        reset = 1'b0; req0 = 1'b1;
        frame0 = 32'h0102_0304; frame1 = 32'hA1A2_A3A4;
        step();
        step();
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            frame0 = $urandom; frame1 = $urandom;
            step();
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (obs[k] !== expv(k)) begin
                    tests_failed++;
                    $display("FAIL preempt_dwell dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], expv(k));
                end
            end
            tests_run++;
            if ({a_gnt0, a_gnt1} !== 2'b10) begin
                tests_failed++;
                $display("FAIL preempt_hold step %0d: got gnt0=%b gnt1=%b expected 1 0", i, a_gnt0, a_gnt1);
            end
        end
        step();
        tests_run++;
        if ({a_gnt0, a_gnt1, a_in3, a_in2, a_in1, a_in0} !== {2'b01, frame1}) begin
            tests_failed++;
            $display("FAIL preempt_switch: got gnt0=%b gnt1=%b %h%h%h%h expected 0 1 %h", a_gnt0, a_gnt1, a_in3, a_in2, a_in1, a_in0, frame1);
        end
    endtask

    task automatic test_release();
        reset = 1'b1;
        step();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        req1 = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs[k] !== expv(k)) begin
                tests_failed++;
                $display("FAIL release_idle dut%0d: got %h expected %h", k, obs[k], expv(k));
            end
        end
        tests_run++;
        if ({a_busy, a_in0} !== {1'b0, 8'hFF}) begin
            tests_failed++;
            $display("FAIL release_blank: got busy=%b in0=%h expected 0 ff", a_busy, a_in0);
        end
        req1 = 1'b1;
        step(); step(); step();
        req1 = 1'b0; req0 = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs[k] !== expv(k)) begin
                tests_failed++;
                $display("FAIL release_handover dut%0d: got %h expected %h", k, obs[k], expv(k));
            end
        end
        tests_run++;
        if ({a_gnt0, a_gnt1, a_busy} !== 3'b101) begin
            tests_failed++;
            $display("FAIL release_no_blank: got %b%b%b expected 101", a_gnt0, a_gnt1, a_busy);
        end
    endtask

    task automatic test_alternate();
        reset = 1'b1;
        step();
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            frame0 = $urandom; frame1 = $urandom;
            step();
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (obs[k] !== expv(k)) begin
                    tests_failed++;
                    $display("FAIL alternate dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], expv(k));
                end
            end
            tests_run++;
            if (b_gnt1 !== (((i / 4) % 2) == 1)) begin
                tests_failed++;
                $display("FAIL alternate_period i=%0d: got gnt1=%b expected %0d", i, b_gnt1, ((i / 4) % 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs[k] !== expv(k)) begin
                tests_failed++;
                $display("FAIL reset_mid dut%0d: got %h expected %h", k, obs[k], expv(k));
            end
        end
        reset = 1'b0; req0 = 1'b1;
        step();
        tests_run++;
        if ({a_gnt0, a_gnt1, b_gnt0, b_gnt1} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL reset_mid_rr: got %b%b %b%b expected 10 10", a_gnt0, a_gnt1, b_gnt0, b_gnt1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) req0 = ~req0;
            if ($urandom_range(0, 5) == 0) req1 = ~req1;
            if ($urandom_range(0, 1) == 0) frame0 = $urandom;
            if ($urandom_range(0, 1) == 0) frame1 = $urandom;
            step();
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (obs[k] !== expv(k)) begin
                    tests_failed++;
                    $display("FAIL random dut%0d cyc %0d: got %h expected %h", k, cyc, obs[k], expv(k));
                end
            end
            tests_run++;
            if ((a_gnt0 && a_gnt1) || (b_gnt0 && b_gnt1)) begin
                tests_failed++;
                $display("FAIL exclusive cyc %0d: got a=%b%b b=%b%b expected at most one grant", cyc, a_gnt0, a_gnt1, b_gnt0, b_gnt1);
            end
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; cyc = 0;
        dwell[0] = 8; dwell[1] = 4;
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_held[k] = 0; m_last[k] = 1; m_out[k] = 32'hFFFF_FFFF;
        end
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        frame0 = '0; frame1 = '0;
        test_reset();
        test_frame();
        test_preempt();
        test_release();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
